// File: rtl/if_id_hazard.sv
// if_id_hazard: PC register, IF/ID pipeline register and load-use / branch-flush control.
// Optional build macro HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module if_id_hazard #(
    parameter logic [29:0] RESET_PC  = 30'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr_,
    input  logic        stall_ext,
    input  logic        branch_taken,
    input  logic [29:0] branch_target,
    input  logic        idex_MemRead,
    input  logic [4:0]  idex_rt,
    output logic [29:0] PC,
    output logic [29:0] PC_4,
    output logic [31:0] Instr,
    output logic        Valid,
    output logic        bubble,
`ifdef HAZARD_STATS_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic [1:0]  state
);
    typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, FLUSH = 2'd2} state_t;

    state_t      curState, nextState;
    logic        hz;
    logic        validNext;
    logic [29:0] pcNext, pc4Next;
    logic [31:0] instrNext;

    assign state = curState;

    // Hazard detection and next-state selection: branch > external stall > load-use > advance
    always_comb begin
        hz        = Valid & idex_MemRead & (idex_rt != 5'd0) &
                    ((idex_rt == Instr[25:21]) | (idex_rt == Instr[20:16]));
        pcNext    = PC;
        pc4Next   = PC_4;
        instrNext = Instr;
        validNext = Valid;
        nextState = curState;
        if (branch_taken) begin
            pcNext    = branch_target;
            instrNext = NOP_INSTR;
            validNext = 1'b0;
            nextState = FLUSH;
        end else if (stall_ext) begin
            nextState = curState;
        end else if (hz) begin
            nextState = LSTALL;
        end else begin
            pcNext    = PC + 30'd1;
            pc4Next   = PC + 30'd1;
            instrNext = Instr_;
            validNext = 1'b1;
            nextState = RUN;
        end
        bubble = rst_n & (branch_taken | stall_ext | hz | ~Valid);
    end

    // PC, IF/ID and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC       <= RESET_PC;
            PC_4     <= 30'd0;
            Instr    <= NOP_INSTR;
            Valid    <= 1'b0;
            curState <= RUN;
        end else begin
            PC       <= pcNext;
            PC_4     <= pc4Next;
            Instr    <= instrNext;
            Valid    <= validNext;
            curState <= nextState;
        end
    end

`ifdef HAZARD_STATS_EN
    logic stallHold;
    assign stallHold = hz & ~branch_taken & ~stall_ext;

    // Saturating counters of load-use hold cycles and taken branches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            stall_cnt <= (stallHold && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
            flush_cnt <= (branch_taken && flush_cnt != 16'hFFFF) ? flush_cnt + 16'd1 : flush_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_if_id_hazard.sv
// tb_if_id_hazard: directed scoreboard bench for if_id_hazard.
module tb_if_id_hazard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Instr_ = 32'h0;
    logic        stall_ext = 1'b0;
    logic        branch_taken = 1'b0;
    logic [29:0] branch_target = 30'h0;
    logic        idex_MemRead = 1'b0;
    logic [4:0]  idex_rt = 5'd0;
    logic [29:0] PC, PC_4;
    logic [31:0] Instr;
    logic        Valid, bubble;
    logic [1:0]  state;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    if_id_hazard dut (
        .clk(clk), .rst_n(rst_n), .Instr_(Instr_), .stall_ext(stall_ext),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
        .PC(PC), .PC_4(PC_4), .Instr(Instr), .Valid(Valid), .bubble(bubble),
`ifdef HAZARD_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] pc;
        logic [29:0] pc4;
        logic [31:0] instr;
        logic        v;
        logic [1:0]  st;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    localparam logic [31:0] LW  = 32'h8C220004;
    localparam logic [31:0] ADD = 32'h00411820;
    localparam logic [31:0] AZ  = 32'h00001820;

    function automatic exp_t mk(logic [29:0] pc, logic [29:0] pc4, logic [31:0] ins, logic v, logic [1:0] st);
        exp_t e;
        e.pc = pc; e.pc4 = pc4; e.instr = ins; e.v = v; e.st = st;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic mr, input logic [4:0] rt,
                        input logic se, input logic bt, input logic [29:0] tgt,
                        input logic expBub, input exp_t e);
        exp_t x;
        Instr_ = ins; idex_MemRead = mr; idex_rt = rt;
        stall_ext = se; branch_taken = bt; branch_target = tgt;
        #1;
        chk("bubble", {31'd0, bubble}, {31'd0, expBub});
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            x = sb.pop_front();
            chk("PC", {2'd0, PC}, {2'd0, x.pc});
            chk("PC_4", {2'd0, PC_4}, {2'd0, x.pc4});
            chk("Instr", Instr, x.instr);
            chk("Valid", {31'd0, Valid}, {31'd0, x.v});
            chk("state", {30'd0, state}, {30'd0, x.st});
        end
    endtask

    initial begin
        #12;
        chk("rst_PC", {2'd0, PC}, 32'd0);
        chk("rst_PC_4", {2'd0, PC_4}, 32'd0);
        chk("rst_Instr", Instr, 32'd0);
        chk("rst_Valid", {31'd0, Valid}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_bubble", {31'd0, bubble}, 32'd0);
        rst_n = 1'b1;
        // reset release, sequential fetch
        step(LW, 0, 0, 0, 0, 0, 1, mk(30'd1, 30'd1, LW, 1, 0));
        step(LW, 0, 0, 0, 0, 0, 0, mk(30'd2, 30'd2, LW, 1, 0));
        step(ADD, 0, 0, 0, 0, 0, 0, mk(30'd3, 30'd3, ADD, 1, 0));
        // load-use hazard on rs=2 holds one cycle
        step(32'h12345678, 1, 5'd2, 0, 0, 0, 1, mk(30'd3, 30'd3, ADD, 1, 1));
        step(32'hAAAA0001, 0, 0, 0, 0, 0, 0, mk(30'd4, 30'd4, 32'hAAAA0001, 1, 0));
        // rt=0 never hazards
        step(AZ, 0, 0, 0, 0, 0, 0, mk(30'd5, 30'd5, AZ, 1, 0));
        step(ADD, 1, 5'd0, 0, 0, 0, 0, mk(30'd6, 30'd6, ADD, 1, 0));
        // branch overrides hz and stall_ext
        step(32'h55555555, 1, 5'd2, 1, 1, 30'h40, 1, mk(30'h40, 30'd6, 32'd0, 0, 2));
        step(32'h11110000, 0, 0, 0, 0, 0, 1, mk(30'h41, 30'h41, 32'h11110000, 1, 0));
        // redirect to top of address space, external stall, then wrap
        step(32'h0, 0, 0, 0, 1, 30'h3FFFFFFF, 1, mk(30'h3FFFFFFF, 30'h41, 32'd0, 0, 2));
        for (int i = 0; i < 3; i++)
            step(32'h9999AAAA, 0, 0, 1, 0, 0, 1, mk(30'h3FFFFFFF, 30'h41, 32'd0, 0, 2));
        step(32'h22220000, 0, 0, 0, 0, 0, 1, mk(30'd0, 30'd0, 32'h22220000, 1, 0));
        // enter LSTALL (rt field 2), then reset between edges
        step(32'h33330000, 1, 5'd2, 0, 0, 0, 1, mk(30'd0, 30'd0, 32'h22220000, 1, 1));
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", {16'd0, stall_cnt}, 32'd2);
        chk("flush_cnt", {16'd0, flush_cnt}, 32'd2);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_PC", {2'd0, PC}, 32'd0);
        chk("mid_PC_4", {2'd0, PC_4}, 32'd0);
        chk("mid_Instr", Instr, 32'd0);
        chk("mid_Valid", {31'd0, Valid}, 32'd0);
        chk("mid_state", {30'd0, state}, 32'd0);
        chk("mid_bubble", {31'd0, bubble}, 32'd0);
`ifdef HAZARD_STATS_EN
        chk("mid_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("mid_flush_cnt", {16'd0, flush_cnt}, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
